div_unit: RTL and testbench

- Iterative radix-2 restoring divider in the EXE stage, directly downstream of the ALU decoder.
- Consumes the 8-bit alucontrol code and performs DIV/DIVU over multiple cycles.
- Returns {remainder, quotient} for the HI/LO registers.
- Raises busy so the hazard unit stalls IF/ID/EXE until the result is ready.

---
 rtl/div_unit.sv | 133 +++++++++++++
 tb/tb_div_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (DIV/DIVU) returning {remainder, quotient} for HI/LO.
// Optional build macro DIV_EARLY_EXIT_EN skips the iteration loop when |a| < |b|.

`ifndef EXE_DIV_OP
`define EXE_DIV_OP  8'b00011010
`endif
`ifndef EXE_DIVU_OP
`define EXE_DIVU_OP 8'b00011011
`endif

module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            alucontrol,
    input  logic                  start,
    input  logic                  annul,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   result,
    output logic                  ready,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ZERO, ON, END} state_t;

    state_t              state, state_nxt;
    logic [5:0]          cnt;
    logic [2*DATA_W:0]   shreg;
    logic [DATA_W-1:0]   divisor;
    logic [DATA_W-1:0]   a_raw;
    logic                signed_op;
    logic                a_neg;
    logic                quot_neg;
    logic [2*DATA_W-1:0] result_q;

    logic                is_div, is_divu, accept, early_exit;
    logic [DATA_W-1:0]   a_mag, b_mag;
    logic [2*DATA_W:0]   shifted, step;
    logic [DATA_W-1:0]   quo, rem, q_fix, r_fix;
    logic [2*DATA_W-1:0] done_val;

    assign is_div  = (alucontrol == `EXE_DIV_OP);
    assign is_divu = (alucontrol == `EXE_DIVU_OP);
    assign accept  = (state == IDLE) && start && !annul && (is_div || is_divu);
    assign a_mag   = (is_div && a[DATA_W-1]) ? (~a + 1'b1) : a;
    assign b_mag   = (is_div && b[DATA_W-1]) ? (~b + 1'b1) : b;

`ifdef DIV_EARLY_EXIT_EN
    assign early_exit = (b != '0) && (a_mag < b_mag);
`else
    assign early_exit = 1'b0;
`endif

    // One restoring step: shift left, subtract the divisor when it fits.
    always_comb begin
        shifted = {shreg[2*DATA_W-1:0], 1'b0};
        step    = shifted;
        if (shifted[2*DATA_W:DATA_W] >= {1'b0, divisor}) begin
            step[2*DATA_W:DATA_W] = shifted[2*DATA_W:DATA_W] - {1'b0, divisor};
            step[0]               = 1'b1;
        end
    end

    always_comb begin
        quo      = shreg[DATA_W-1:0];
        rem      = shreg[2*DATA_W-1:DATA_W];
        q_fix    = (signed_op && quot_neg) ? (~quo + 1'b1) : quo;
        r_fix    = (signed_op && a_neg) ? (~rem + 1'b1) : rem;
        done_val = (state == ZERO) ? {a_raw, {DATA_W{1'b1}}} : {r_fix, q_fix};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (b == '0)
                        state_nxt = ZERO;
                    else if (early_exit)
                        state_nxt = END;
                    else
                        state_nxt = ON;
                end
            end
            ZERO:    state_nxt = IDLE;
            ON:      if (cnt == 6'(DATA_W-1)) state_nxt = END;
            END:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (annul && state != IDLE)
            state_nxt = IDLE;
    end

    // The result output shows the fresh value while ready, otherwise the last delivered one,
    // so an annulled END/ZERO cycle leaves the visible result untouched.
    assign ready  = ((state == ZERO) || (state == END)) && !annul;
    assign busy   = (state != IDLE);
    assign result = ready ? done_val : result_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            divisor   <= '0;
            a_raw     <= '0;
            signed_op <= 1'b0;
            a_neg     <= 1'b0;
            quot_neg  <= 1'b0;
            result_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                signed_op <= is_div;
                a_neg     <= a[DATA_W-1];
                quot_neg  <= a[DATA_W-1] ^ b[DATA_W-1];
                a_raw     <= a;
                divisor   <= b_mag;
                cnt       <= '0;
                shreg     <= early_exit ? {1'b0, a_mag, {DATA_W{1'b0}}}
                                        : {{(DATA_W+1){1'b0}}, a_mag};
            end else if (state == ON) begin
                shreg <= step;
                cnt   <= (cnt == 6'(DATA_W-1)) ? 6'd0 : cnt + 6'd1;
            end
            if (ready)
                result_q <= done_val;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vectors with hand-computed results and latencies.

`ifndef EXE_DIV_OP
`define EXE_DIV_OP  8'b00011010
`endif
`ifndef EXE_DIVU_OP
`define EXE_DIVU_OP 8'b00011011
`endif
`ifndef EXE_ADD_OP
`define EXE_ADD_OP  8'b00100000
`endif

module tb_div_unit;

    logic        clk;
    logic        rst;
    logic [7:0]  alucontrol;
    logic        start;
    logic        annul;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] result;
    logic        ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

`ifdef DIV_EARLY_EXIT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 33;
`endif

    div_unit #(.DATA_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .alucontrol(alucontrol),
        .start(start),
        .annul(annul),
        .a(a),
        .b(b),
        .result(result),
        .ready(ready),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Drive one request at a falling edge, let it be accepted, then scramble the operands.
    task automatic applyStimulus(input logic [7:0] op, input logic [31:0] av, input logic [31:0] bv);
        alucontrol = op;
        a          = av;
        b          = bv;
        annul      = 1'b0;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        alucontrol = `EXE_ADD_OP;
        a          = 32'hDEAD_BEEF;
        b          = 32'h0;
    endtask

    task automatic waitReady(output int edges, output logic busy_ok);
        edges   = 1;
        busy_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (ready === 1'b1) break;
            edges++;
        end
    endtask

    task automatic runDiv(input string tag, input logic [7:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input logic [63:0] exp_res, input int exp_lat);
        int   edges;
        logic busy_ok;
        applyStimulus(op, av, bv);
        waitReady(edges, busy_ok);
        checkOutput({tag, "_result"}, result, exp_res);
        checkOutput({tag, "_latency"}, 64'(edges), 64'(exp_lat));
        checkOutput({tag, "_busy"}, {63'd0, busy_ok}, 64'd1);
        @(negedge clk);
        checkOutput({tag, "_after"}, {result, 1'b0, ready, busy}, {exp_res, 3'b000});
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        rst        = 1'b1;
        alucontrol = 8'h0;
        start      = 1'b0;
        annul      = 1'b0;
        a          = 32'h0;
        b          = 32'h0;
        #2;
        checkOutput("reset_state", {result, ready, busy}, 66'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        runDiv("divu_100_7",   `EXE_DIVU_OP, 32'd100,       32'd7,        {32'h2, 32'hE}, 33);
        runDiv("div_m7_2",     `EXE_DIV_OP,  32'hFFFF_FFF9, 32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        runDiv("div_ovf",      `EXE_DIV_OP,  32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);
        runDiv("divu_big",     `EXE_DIVU_OP, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, EARLY_LAT);
        runDiv("divu_zero",    `EXE_DIVU_OP, 32'h1234,      32'h0,        {32'h1234, 32'hFFFF_FFFF}, 1);
        runDiv("div_100_m7",   `EXE_DIV_OP,  32'd100,       32'hFFFF_FFF9, {32'd2, 32'hFFFF_FFF2}, 33);
        runDiv("div_m5_m9",    `EXE_DIV_OP,  32'hFFFF_FFFB, 32'hFFFF_FFF7, {32'hFFFF_FFFB, 32'h0}, EARLY_LAT);

        // Annul in the middle of the iterations: no ready pulse, result keeps the last value.
        applyStimulus(`EXE_DIVU_OP, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        annul = 1'b1;
        #1;
        checkOutput("annul_on_ready", {63'd0, ready}, 64'd0);
        @(negedge clk);
        annul = 1'b0;
        checkOutput("annul_on_idle", {result, ready, busy}, {32'hFFFF_FFFB, 32'h0, 2'b00});
        @(negedge clk);
        checkOutput("annul_on_quiet", {63'd0, ready}, 64'd0);
        runDiv("divu_9_3",     `EXE_DIVU_OP, 32'd9,         32'd3,        {32'h0, 32'h3}, 33);

        // Annul on the divide-by-zero answer cycle suppresses ready and keeps the result.
        applyStimulus(`EXE_DIVU_OP, 32'h55, 32'h0);
        #2;
        annul = 1'b1;
        #1;
        checkOutput("annul_zero", {result, ready, busy}, {32'h0, 32'h3, 2'b01});
        @(posedge clk);
        #1;
        annul = 1'b0;
        checkOutput("annul_zero_idle", {result, ready, busy}, {32'h0, 32'h3, 2'b00});
        @(negedge clk);

        // Asynchronous reset between edges while iterating.
        applyStimulus(`EXE_DIVU_OP, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset", {result, ready, busy}, 66'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // start together with annul, and a non-divide op code, are both ignored.
        alucontrol = `EXE_DIV_OP;
        a          = 32'd50;
        b          = 32'd5;
        start      = 1'b1;
        annul      = 1'b1;
        @(negedge clk);
        checkOutput("start_annul", {63'd0, busy}, 64'd0);
        annul      = 1'b0;
        alucontrol = `EXE_ADD_OP;
        @(negedge clk);
        checkOutput("start_add", {63'd0, busy}, 64'd0);
        start = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
